ip_uart_arbiter: RTL and testbench

IP_UART_ARBITER -- requirements
Module: ip_uart_arbiter

---
 rtl/ip_uart_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_ip_uart_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_uart_arbiter.sv
// ---------------------------------------------------------------------------
// ip_uart_arbiter
//
// Shares one ip_uart transmitter between four byte-producing ports.
// Ports are served round-robin one byte at a time. A port that raises its
// lock bit keeps the transmitter after its byte so it can send a multi-byte
// message without interleaving. A locked owner that stays silent for
// HOLD_TIMEOUT cycles loses the grant.
//
// Parameters
//   HOLD_TIMEOUT   idle cycles a locked owner may keep the grant (1..65535)
//
// Ports
//   clk            system clock, rising edge
//   n_reset        synchronous active-low reset
//   req_data       byte of port i on bits [8i+7:8i]
//   req            per-port send request, held with stable data until acked
//   lock           per-port request to keep the grant after the current byte
//   busy           per-port acknowledge, low for one cycle when byte taken
//   grant          index of the current owner port
//   grant_valid    high while a byte is in flight or the owner holds the grant
//   uart_send_data byte presented to ip_uart
//   uart_send_req  request to ip_uart
//   uart_send_busy ip_uart busy; byte taken when req=1 and busy=0
// ---------------------------------------------------------------------------
module ip_uart_arbiter #(
    parameter logic [15:0] HOLD_TIMEOUT = 16'd27000
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic [31:0] req_data,
    input  logic [3:0]  req,
    input  logic [3:0]  lock,
    output logic [3:0]  busy,
    output logic [1:0]  grant,
    output logic        grant_valid,
    output logic [7:0]  uart_send_data,
    output logic        uart_send_req,
    input  logic        uart_send_busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg,    state_next;
    logic [7:0]  data_reg,     data_next;
    logic        send_req_reg, send_req_next;
    logic [3:0]  busy_reg,     busy_next;
    logic [1:0]  grant_reg,    grant_next;
    logic [1:0]  last_reg,     last_next;
    logic [3:0]  armed_reg,    armed_next;
    logic [15:0] hold_cnt_reg, hold_cnt_next;

    // Per-port byte lanes.
    logic [7:0] port_byte [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign port_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // A port may only be served once per request assertion: armed drops on
    // acknowledge and comes back only after the port has released req.
    logic [3:0] eligible;
    assign eligible = req & armed_reg;

    // Round-robin candidates in scan order: cand[0] = last+1, cand[3] = last.
    logic [1:0] cand [4];
    logic [3:0] cand_elig;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            localparam logic [1:0] OFFSET = 2'(gi + 1);
            assign cand[gi]      = last_reg + OFFSET;
            assign cand_elig[gi] = eligible[cand[gi]];
        end
    endgenerate

    logic       rr_found;
    logic [1:0] rr_port;

    // Descending loop so the earliest candidate in scan order wins.
    always_comb begin
        rr_found = 1'b0;
        rr_port  = last_reg;
        for (int k = 3; k >= 0; k--) begin
            if (cand_elig[k]) begin
                rr_found = 1'b1;
                rr_port  = cand[k];
            end
        end
    end

    logic        owner_eligible;
    logic        owner_release;
    logic [15:0] hold_cnt_inc;

    assign owner_eligible = eligible[grant_reg];
    assign owner_release  = !lock[grant_reg] && !req[grant_reg];
    assign hold_cnt_inc   = hold_cnt_reg + 16'd1;

    always_comb begin
        state_next    = state_reg;
        data_next     = data_reg;
        send_req_next = send_req_reg;
        busy_next     = 4'hF;               // acknowledge is a single-cycle pulse
        grant_next    = grant_reg;
        last_next     = last_reg;
        armed_next    = armed_reg | ~req;   // re-arm any port that released req
        hold_cnt_next = hold_cnt_reg;

        case (state_reg)
            IDLE: begin
                hold_cnt_next = 16'd0;
                if (rr_found) begin
                    data_next           = port_byte[rr_port];
                    grant_next          = rr_port;
                    last_next           = rr_port;
                    busy_next[rr_port]  = 1'b0;
                    armed_next[rr_port] = 1'b0;
                    send_req_next       = 1'b1;
                    state_next          = SEND;
                end
            end

            SEND: begin
                hold_cnt_next = 16'd0;
                if (!uart_send_busy) begin
                    send_req_next = 1'b0;
                    state_next    = lock[grant_reg] ? HOLD : IDLE;
                end
            end

            HOLD: begin
                if (owner_eligible) begin
                    // Next byte of a locked message; last is left alone so the
                    // round-robin position is not disturbed by the lock.
                    data_next             = port_byte[grant_reg];
                    busy_next[grant_reg]  = 1'b0;
                    armed_next[grant_reg] = 1'b0;
                    send_req_next         = 1'b1;
                    hold_cnt_next         = 16'd0;
                    state_next            = SEND;
                end else if (owner_release) begin
                    hold_cnt_next = 16'd0;
                    state_next    = IDLE;
                end else if (hold_cnt_inc >= HOLD_TIMEOUT) begin
                    hold_cnt_next = 16'd0;
                    state_next    = IDLE;
                end else begin
                    hold_cnt_next = hold_cnt_inc;
                end
            end

            default: begin
                state_next    = IDLE;
                send_req_next = 1'b0;
                hold_cnt_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_reg    <= IDLE;
            data_reg     <= 8'd0;
            send_req_reg <= 1'b0;
            busy_reg     <= 4'hF;
            grant_reg    <= 2'd0;
            last_reg     <= 2'd3;     // port 0 is scanned first after reset
            armed_reg    <= 4'hF;
            hold_cnt_reg <= 16'd0;
        end else begin
            state_reg    <= state_next;
            data_reg     <= data_next;
            send_req_reg <= send_req_next;
            busy_reg     <= busy_next;
            grant_reg    <= grant_next;
            last_reg     <= last_next;
            armed_reg    <= armed_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    assign busy           = busy_reg;
    assign grant          = grant_reg;
    assign grant_valid    = (state_reg != IDLE);
    assign uart_send_data = data_reg;
    assign uart_send_req  = send_req_reg;

endmodule

// File: tb/tb_ip_uart_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ip_uart_arbiter
//
// Bench for ip_uart_arbiter with HOLD_TIMEOUT = 10. A behavioural model
// predicts every output each cycle; directed scenarios add literal checks,
// then randomized port agents exercise the arbiter.
// ---------------------------------------------------------------------------
module tb_ip_uart_arbiter;

    localparam int HOLD_TO = 10;

    logic        clk;
    logic        n_reset;
    logic [31:0] req_data;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [3:0]  busy;
    logic [1:0]  grant;
    logic        grant_valid;
    logic [7:0]  uart_send_data;
    logic        uart_send_req;
    logic        uart_send_busy;

    ip_uart_arbiter #(.HOLD_TIMEOUT(16'(HOLD_TO))) dut (
        .clk            (clk),
        .n_reset        (n_reset),
        .req_data       (req_data),
        .req            (req),
        .lock           (lock),
        .busy           (busy),
        .grant          (grant),
        .grant_valid    (grant_valid),
        .uart_send_data (uart_send_data),
        .uart_send_req  (uart_send_req),
        .uart_send_busy (uart_send_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 = nobody owns the uart, 1 = a byte is waiting for ip_uart,
    //        2 = locked owner keeps the uart between bytes.
    int         m_phase;
    logic [7:0] m_data;
    logic [1:0] m_grant;
    logic [1:0] m_last;
    logic [3:0] m_armed;
    logic [3:0] m_busy;
    int         m_cnt;

    always @(posedge clk) begin : model
        logic [3:0] el;
        logic [3:0] nb;
        logic [3:0] na;
        logic [1:0] p;
        bit         found;
        el = req & m_armed;
        na = m_armed | ~req;
        nb = 4'hF;
        if (!n_reset) begin
            m_phase = 0; m_data = 8'd0; m_grant = 2'd0; m_last = 2'd3;
            m_armed = 4'hF; m_busy = 4'hF; m_cnt = 0;
        end else begin
            case (m_phase)
                0: begin
                    found = 1'b0;
                    for (int k = 1; k <= 4; k++) begin
                        p = 2'((int'(m_last) + k) % 4);
                        if (!found && el[p]) begin
                            found = 1'b1;
                            m_data = req_data[8*p +: 8];
                            m_grant = p; m_last = p;
                            nb[p] = 1'b0; na[p] = 1'b0;
                            m_phase = 1;
                        end
                    end
                    m_cnt = 0;
                end
                1: begin
                    m_cnt = 0;
                    if (!uart_send_busy) m_phase = lock[m_grant] ? 2 : 0;
                end
                default: begin
                    if (el[m_grant]) begin
                        m_data = req_data[8*m_grant +: 8];
                        nb[m_grant] = 1'b0; na[m_grant] = 1'b0;
                        m_phase = 1; m_cnt = 0;
                    end else if (!lock[m_grant] && !req[m_grant]) begin
                        m_phase = 0; m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt >= HOLD_TO) begin m_phase = 0; m_cnt = 0; end
                    end
                end
            endcase
            m_busy = nb;
            m_armed = na;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("cycle", {16'd0, busy, grant, grant_valid, uart_send_req, uart_send_data},
                {16'd0, m_busy, m_grant, (m_phase != 0), (m_phase == 1), m_data});
            chk("one_busy_low", 32'($countones(~busy) <= 1), 32'd1);
        end
    end

    // Log of bytes handed to ip_uart, one line per transaction.
    logic [1:0] log_port [$];
    logic [7:0] log_data [$];

    always @(negedge clk) begin
        if (uart_send_req && !uart_send_busy) begin
            log_port.push_back(grant);
            log_data.push_back(uart_send_data);
            $display("t=%0t take port %0d byte %02h", $time, grant, uart_send_data);
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0; req = 4'h0; lock = 4'h0;
        tick(); tick();
        n_reset = 1'b1;
        log_port.delete(); log_data.delete();
    endtask

    task automatic wait_ack(input int p, input int bound, input string name);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < bound; c++) begin
            tick();
            if (busy[p] == 1'b0) begin ok = 1'b1; break; end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    bit   acked  [4];
    int   linger [4];
    int   order  [$];
    int   hold_cycles, idle_cycles;
    bit   flag;

    initial begin
        n_reset = 1'b0; req = 4'h0; lock = 4'h0; req_data = 32'h0; uart_send_busy = 1'b0;
        tick();
        check_en = 1'b1;
        chk("reset_outputs", {16'd0, busy, grant, grant_valid, uart_send_req, uart_send_data},
            {16'd0, 4'hF, 2'd0, 1'b0, 1'b0, 8'h00});
        tick();
        n_reset = 1'b1;

        // Single byte from port 2.
        do_reset();
        uart_send_busy = 1'b0;
        req_data[23:16] = 8'h48; req[2] = 1'b1;
        wait_ack(2, 20, "single_ack");
        chk("single_data", 32'(uart_send_data), 32'h48);
        chk("single_grant", 32'(grant), 32'd2);
        chk("single_busy", 32'(busy), 32'hB);
        chk("single_req_hi", 32'(uart_send_req), 32'd1);
        chk("model_single", {22'd0, m_grant, m_data}, {22'd0, 2'd2, 8'h48});
        req[2] = 1'b0;
        tick();
        chk("single_req_lo", 32'(uart_send_req), 32'd0);
        chk("single_count", 32'(log_data.size()), 32'd1);

        // Round-robin with every port re-raising after its ack.
        do_reset();
        req_data = 32'hA3A2A1A0; req = 4'hF; order.delete();
        for (int c = 0; c < 100 && order.size() < 5; c++) begin
            tick();
            for (int i = 0; i < 4; i++) begin
                if (busy[i] == 1'b0) begin order.push_back(i); req[i] = 1'b0; end
                else if (!req[i]) req[i] = 1'b1;
            end
        end
        req = 4'h0;
        chk("rr_count", 32'(order.size()), 32'd5);
        for (int k = 0; k < 5 && k < order.size(); k++)
            chk("rr_order", 32'(order[k]), 32'(k % 4));

        // Locked two-byte message from port 1 while port 0 waits.
        do_reset();
        lock[1] = 1'b1; req_data[15:8] = 8'h48; req[1] = 1'b1;
        wait_ack(1, 20, "lock_ack_h");
        req[1] = 1'b0; req_data[7:0] = 8'h30; req[0] = 1'b1;
        tick();
        req_data[15:8] = 8'h69; req[1] = 1'b1;
        wait_ack(1, 20, "lock_ack_i");
        req[1] = 1'b0; lock[1] = 1'b0;
        wait_ack(0, 50, "lock_ack_p0");
        req[0] = 1'b0;
        tick(); tick();
        chk("lock_count", 32'(log_data.size()), 32'd3);
        if (log_data.size() == 3) begin
            chk("lock_b0", {22'd0, log_port[0], log_data[0]}, {22'd0, 2'd1, 8'h48});
            chk("lock_b1", {22'd0, log_port[1], log_data[1]}, {22'd0, 2'd1, 8'h69});
            chk("lock_b2", {22'd0, log_port[2], log_data[2]}, {22'd0, 2'd0, 8'h30});
        end

        // Hold timeout: port 3 locked and silent, port 0 waiting.
        do_reset();
        lock[3] = 1'b1; req_data[31:24] = 8'h33; req[3] = 1'b1;
        wait_ack(3, 20, "to_ack3");
        req[3] = 1'b0; req_data[7:0] = 8'h55; req[0] = 1'b1;
        hold_cycles = 0; idle_cycles = 0; flag = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (busy[0] == 1'b0) begin flag = 1'b1; break; end
            if (grant_valid && !uart_send_req) hold_cycles++;
            else if (!grant_valid) idle_cycles++;
        end
        chk("to_ack0", 32'(flag), 32'd1);
        chk("to_hold_cycles", 32'(hold_cycles), 32'(HOLD_TO));
        chk("to_idle_cycles", 32'(idle_cycles), 32'd1);
        req[0] = 1'b0; lock[3] = 1'b0;
        tick();

        // Backpressure for 500 cycles with another port waiting.
        do_reset();
        uart_send_busy = 1'b1;
        req_data[15:8] = 8'h77; req[1] = 1'b1;
        wait_ack(1, 20, "bp_ack1");
        req[1] = 1'b0; req_data[23:16] = 8'h22; req[2] = 1'b1;
        flag = 1'b1;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (!(uart_send_req && uart_send_data == 8'h77 && busy == 4'hF && grant == 2'd1))
                flag = 1'b0;
        end
        chk("bp_stable", 32'(flag), 32'd1);
        uart_send_busy = 1'b0;
        tick();
        chk("bp_taken", 32'(uart_send_req), 32'd0);
        wait_ack(2, 20, "bp_ack2");
        req[2] = 1'b0;
        tick();
        chk("bp_count", 32'(log_data.size()), 32'd2);
        if (log_data.size() == 2) begin
            chk("bp_b0", {22'd0, log_port[0], log_data[0]}, {22'd0, 2'd1, 8'h77});
            chk("bp_b1", {22'd0, log_port[1], log_data[1]}, {22'd0, 2'd2, 8'h22});
        end

        // Reset in the middle of SEND.
        do_reset();
        uart_send_busy = 1'b1;
        req_data[23:16] = 8'h11; req[2] = 1'b1;
        wait_ack(2, 20, "rst_ack2");
        tick();
        n_reset = 1'b0; req[2] = 1'b0;
        tick();
        chk("rst_outputs", {16'd0, busy, grant, grant_valid, uart_send_req, uart_send_data},
            {16'd0, 4'hF, 2'd0, 1'b0, 1'b0, 8'h00});
        n_reset = 1'b1; uart_send_busy = 1'b0;
        flag = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (uart_send_req || busy != 4'hF) flag = 1'b0;
        end
        chk("rst_no_retry", 32'(flag), 32'd1);
        chk("rst_count", 32'(log_data.size()), 32'd0);

        // Randomized traffic checked cycle by cycle against the model.
        for (int i = 0; i < 4; i++) begin acked[i] = 1'b0; linger[i] = 0; end
        req = 4'h0; lock = 4'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            n_reset = ($urandom_range(0, 799) != 0);
            uart_send_busy = ($urandom_range(0, 4) < 2);
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    if (busy[i] == 1'b0) acked[i] = 1'b1;
                    if (acked[i]) begin
                        if (linger[i] == 0) begin req[i] = 1'b0; acked[i] = 1'b0; end
                        else linger[i]--;
                    end
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                    linger[i] = $urandom_range(0, 2);
                end
                if ($urandom_range(0, 7) == 0) lock[i] = ~lock[i];
            end
        end
        req = 4'h0; lock = 4'h0; n_reset = 1'b1;
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
